// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
//   Multi-nibble (W = 4*NIBBLES bit) adder/subtractor that works serially,
//   one nibble per clock and least significant nibble first, on top of a
//   single 4-bit add/sub stage. The carry between nibbles lives in a
//   register. A start/busy/done handshake connects it to the requesting
//   logic. The result, the unsigned carry/borrow and the signed overflow
//   are held until the next operation writes over them.
//
// Handshake: start is sampled only in IDLE or DONE, and a, b and sub are
//   captured on that edge. busy is high for exactly NIBBLES cycles (state
//   RUN). done is then high for one cycle (state DONE). A start seen in
//   DONE relaunches at once. A start seen in RUN is dropped and not queued.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   operation request
//   sub        in   0 = a+b, 1 = a-b
//   a, b       in   W-bit operands
//   busy       out  high while the operation runs
//   done       out  one-cycle pulse; result/cout/overflow valid
//   result     out  W-bit sum/difference modulo 2^W
//   cout       out  final carry (for sub: 1 = no borrow)
//   overflow   out  signed overflow of the full-width operation
//   dbg_state  out  current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)

module nibble_addsub4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       sub_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o,
    output logic       c3_o
);
    logic [3:0] bx;
    logic [4:0] s;
    logic [3:0] low;

    // Subtraction is a + ~b + 1. The +1 comes in through cin, which the
    // controller seeds with sub.
    assign bx     = b_i ^ {4{sub_i}};
    assign s      = {1'b0, a_i} + {1'b0, bx} + {4'b0000, cin_i};
    // Carry into bit 3 is needed for the signed overflow of the top nibble.
    assign low    = {1'b0, a_i[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin_i};
    assign sum_o  = s[3:0];
    assign cout_o = s[4];
    assign c3_o   = low[3];
endmodule

module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic [1:0]   dbg_state
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sub_q, sub_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    nib_a, nib_b, nib_sum;
    logic          nib_cout, nib_c3;

    // The nibble being worked on is picked by idx from the captured operands,
    // so a/b/sub on the ports are free to change during RUN.
    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4];

    nibble_addsub4 u_stage (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .sub_i  (sub_q),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout),
        .c3_o   (nib_c3)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_cout;
                    ovf_d   = nib_c3 ^ nib_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
module tb_nibble_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub;
    logic [15:0] a, b;
    logic        busy, done, cout, overflow;
    logic [15:0] result;
    logic [1:0]  dbg;

    logic        start1, sub1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1, overflow1;
    logic [3:0]  result1;
    logic [1:0]  dbg1;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .dbg_state(dbg)
    );

    nibble_serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1),
        .overflow(overflow1), .dbg_state(dbg1)
    );

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                  input bit ts, output logic [15:0] r, output bit c, output bit v);
        longint m, ua, ub, res, sa, sb, sres;
        m  = longint'(1) << w;
        ua = longint'(ta);
        ub = longint'(tb_);
        if (ts) begin
            res = ua - ub;
            c   = (ua >= ub);
        end else begin
            res = ua + ub;
            c   = (res >= m);
        end
        if (res < 0) res = res + m;
        r    = 16'(res % m);
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        sres = ts ? sa - sb : sa + sb;
        v    = (sres >= m / 2) || (sres < -(m / 2));
    endfunction

    // Driver: called at a negedge, returns at the negedge after the capture edge.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input bit ts);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done on the selected instance, counting busy cycles.
    task automatic wait_done(input bit which, output int cyc, output int bcnt, output bit to);
        cyc = 0; bcnt = 0;
        while (((which ? done1 : done) == 1'b0) && cyc < 50) begin
            if (which ? busy1 : busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        to = ((which ? done1 : done) == 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; sub = 0; a = 16'hFFFF; b = 16'hFFFF;
        start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0000 || result !== 16'h0 || dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b res=%h cout=%b ovf=%b st=%0d exp all 0",
                     busy, done, result, cout, overflow, dbg);
        end
        checks++;
        if ({busy1, done1, cout1, overflow1} !== 4'b0000 || result1 !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs_n1 got busy=%b done=%b res=%h exp all 0", busy1, done1, result1);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dbg !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b st=%0d exp 0/0", busy, dbg);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va[4], vb[4], er;
        bit vs[4], ec, ev, to;
        int cyc, bcnt;
        va = '{16'h1234, 16'hA0A0, 16'h0003, 16'h8000};
        vb = '{16'h0FFF, 16'h6F60, 16'h0005, 16'h0001};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            model(16, va[i], vb[i], vs[i], er, ec, ev);
            launch(va[i], vb[i], vs[i]);
            wait_done(1'b0, cyc, bcnt, to);
            checks++;
            if (to || cyc != 4 || bcnt != 4) begin
                errors++;
                $display("FAIL dir%0d_latency got cyc=%0d busy=%0d timeout=%b exp 4/4/0", i, cyc, bcnt, to);
            end
            checks++;
            if (result !== er || cout !== ec || overflow !== ev) begin
                errors++;
                $display("FAIL dir%0d_value got %h c=%b v=%b exp %h c=%b v=%b",
                         i, result, cout, overflow, er, ec, ev);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== er || cout !== ec || overflow !== ev) begin
                errors++;
                $display("FAIL dir%0d_hold got done=%b %h c=%b v=%b exp done=0 %h c=%b v=%b",
                         i, done, result, cout, overflow, er, ec, ev);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ta, tb_, er;
        logic [17:0] exp;
        bit ts, ec, ev, to;
        int cyc, bcnt;
        for (int i = 0; i < 16; i++) begin
            ta = 16'($urandom_range(0, 65535));
            tb_ = 16'($urandom_range(0, 65535));
            ts = 1'($urandom_range(0, 1));
            model(16, ta, tb_, ts, er, ec, ev);
            exp_q.push_back({ev, ec, er});
            launch(ta, tb_, ts);
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            wait_done(1'b0, cyc, bcnt, to);
            exp = exp_q.pop_front();
            checks++;
            if (to || {overflow, cout, result} !== exp) begin
                errors++;
                $display("FAIL rand%0d got %h c=%b v=%b exp %h c=%b v=%b timeout=%b",
                         i, result, cout, overflow, exp[15:0], exp[16], exp[17], to);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] er;
        bit ec, ev, to;
        int cyc, bcnt, ndone;
        model(16, 16'h4321, 16'h1111, 1'b0, er, ec, ev);
        launch(16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0F0F; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to || result !== er || cout !== ec || overflow !== ev) begin
            errors++;
            $display("FAIL ignored_start_value got %h c=%b v=%b exp %h c=%b v=%b timeout=%b",
                     result, cout, overflow, er, ec, ev, to);
        end
        ndone = done ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignored_start_done_count got %0d exp 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta[4], tb_[4], er;
        bit ts[4], ec, ev;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 16'($urandom); tb_[i] = 16'($urandom); ts[i] = 1'($urandom);
        end
        a = ta[0]; b = tb_[0]; sub = ts[0]; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 20);
            model(16, ta[k], tb_[k], ts[k], er, ec, ev);
            checks++;
            if (!done || cyc != 5) begin
                errors++;
                $display("FAIL b2b%0d_interval got %0d done=%b exp 5", k, cyc, done);
            end
            checks++;
            if (result !== er || cout !== ec || overflow !== ev) begin
                errors++;
                $display("FAIL b2b%0d_value got %h c=%b v=%b exp %h c=%b v=%b",
                         k, result, cout, overflow, er, ec, ev);
            end
            if (k < 3) begin
                a = ta[k+1]; b = tb_[k+1]; sub = ts[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || dbg !== 2'd0) begin
            errors++;
            $display("FAIL b2b_end got done=%b st=%0d exp 0/0", done, dbg);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] er;
        bit ec, ev, to;
        int cyc, bcnt, ndone;
        launch(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0000 || result !== 16'h0 || dbg !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b res=%h c=%b v=%b st=%0d exp all 0",
                     busy, done, result, cout, overflow, dbg);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_abort got %0d active cycles exp 0", ndone);
        end
        model(16, 16'h7FFF, 16'h0001, 1'b0, er, ec, ev);
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to || result !== er || cout !== ec || overflow !== ev) begin
            errors++;
            $display("FAIL after_reset_op got %h c=%b v=%b exp %h c=%b v=%b timeout=%b",
                     result, cout, overflow, er, ec, ev, to);
        end
    endtask

    task automatic test_nibbles1();
        logic [15:0] er;
        logic [3:0] ta, tb_;
        bit ts, ec, ev, to;
        int cyc, bcnt;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                ta = 4'hA; tb_ = 4'hA; ts = 1'b0;
            end else begin
                ta = 4'($urandom); tb_ = 4'($urandom); ts = 1'($urandom);
            end
            model(4, {12'h0, ta}, {12'h0, tb_}, ts, er, ec, ev);
            a1 = ta; b1 = tb_; sub1 = ts; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            wait_done(1'b1, cyc, bcnt, to);
            checks++;
            if (to || cyc != 1 || bcnt != 1) begin
                errors++;
                $display("FAIL n1_%0d_latency got cyc=%0d busy=%0d timeout=%b exp 1/1/0", i, cyc, bcnt, to);
            end
            checks++;
            if (result1 !== er[3:0] || cout1 !== ec || overflow1 !== ev) begin
                errors++;
                $display("FAIL n1_%0d_value got %h c=%b v=%b exp %h c=%b v=%b",
                         i, result1, cout1, overflow1, er[3:0], ec, ev);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_nibbles1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
